toggle_pulse_tx: RTL

Source-side transmitter for the toggle pulse-synchronization protocol with a returned acknowledge. It accepts single-cycle event pulses in its own clock domain and counts them in a saturating pending counter. It launches one request per event by flipping a level signal (`req_tgl`), then waits for the receiving domain to echo that level back on `ack_tgl` before launching the next. This pacing means back-to-back source pulses are never merged or lost at the receiver, unlike a bare toggle synchronizer.

---
 rtl/toggle_pulse_tx.sv | 91 +++++++++
 1 files changed

// File: rtl/toggle_pulse_tx.sv
// Source side of a toggle pulse synchronizer: counts local event pulses and
// launches them one at a time as req_tgl flips, pacing each on the echoed ack.
module toggle_pulse_tx #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             ack_tgl,
    output logic             req_tgl,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             done,
    output logic             overflow
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   launch;

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // A launch also requires the echo to match, so a mismatched ack in IDLE
    // (only possible after a broken joint reset) simply stalls the FSM.
    assign launch = (state == IDLE) && (pending != '0) && (ack_s == req_tgl);

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_tgl  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            pending  <= '0;
        end else begin
            done     <= 1'b0;
            overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (launch) begin
                        state   <= WAIT_ACK;
                        req_tgl <= ~req_tgl;
                        busy    <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s == req_tgl) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // An event arriving on a launch cycle replaces the launched one,
            // so it is accepted even when the counter is saturated.
            if (pulse_in && !launch) begin
                if (pending == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + 1'b1;
                end
            end else if (!pulse_in && launch) begin
                pending <= pending - 1'b1;
            end
        end
    end

endmodule
